// File: rtl/capt_sched.sv
// Capture scheduler: arbitrates NCH asynchronous event inputs round-robin onto a
// single timestamp capture latch, then handles the readout / re-arm handshake.
module capt_sched #(
    parameter int  NCH     = 4,
    parameter int  HOLDOFF = 2,
    localparam int CW      = (NCH > 2) ? $clog2(NCH) : 1
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic [NCH-1:0] EV,
    input  logic           RD_DONE,
    input  logic           OVF_CLR,
    output logic           CAPT_O,
    output logic           RSTCAPT_O,
    output logic [CW-1:0]  CHAN,
    output logic           INT,
    output logic [NCH-1:0] PEND,
    output logic [NCH-1:0] OVF
);

    localparam int HW    = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam int HLAST = (HOLDOFF > 0) ? HOLDOFF - 1 : 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAPTURE,
        S_WAIT_RD,
        S_REARM,
        S_HOLDOFF
    } state_t;

    state_t         state_reg, state_next;
    logic           capt_reg, capt_next;
    logic           rstcapt_reg, rstcapt_next;
    logic           int_reg, int_next;
    logic [CW-1:0]  chan_reg, chan_next;
    logic [CW-1:0]  ptr_reg, ptr_next;
    logic [HW-1:0]  cnt_reg, cnt_next;
    logic [NCH-1:0] pend_reg, pend_next;
    logic [NCH-1:0] ovf_reg, ovf_next;
    logic [NCH-1:0] ovf_set;
    logic [NCH-1:0] edge_det;
    logic [NCH-1:0] grant_vec;
    logic [CW-1:0]  pick;
    logic [CW-1:0]  cand;
    logic           pick_valid;

    // Two flops resolve metastability; the third holds the previous level for edge detection.
    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_sync
            logic [2:0] sync_reg;
            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    sync_reg <= 3'b000;
                end else begin
                    sync_reg <= {sync_reg[1:0], EV[gi]};
                end
            end
            assign edge_det[gi] = sync_reg[1] & ~sync_reg[2];
        end
    endgenerate

    // A grant consumes the pending flag; a fresh edge in the same cycle re-arms it cleanly.
    always_comb begin
        ovf_set   = edge_det & pend_reg & ~grant_vec;
        pend_next = (pend_reg & ~grant_vec) | edge_det;
        ovf_next  = (OVF_CLR ? '0 : ovf_reg) | ovf_set;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pend_reg <= '0;
            ovf_reg  <= '0;
        end else begin
            pend_reg <= pend_next;
            ovf_reg  <= ovf_next;
        end
    end

    // Round-robin search starting one past the last granted channel.
    always_comb begin
        pick       = '0;
        pick_valid = 1'b0;
        cand       = ptr_reg;
        for (int off = 0; off < NCH; off++) begin
            cand = (cand == CW'(NCH - 1)) ? '0 : cand + 1'b1;
            if (!pick_valid && pend_reg[cand]) begin
                pick       = cand;
                pick_valid = 1'b1;
            end
        end
    end

    always_comb begin
        state_next   = state_reg;
        capt_next    = 1'b0;
        rstcapt_next = 1'b0;
        int_next     = int_reg;
        chan_next    = chan_reg;
        ptr_next     = ptr_reg;
        cnt_next     = cnt_reg;
        grant_vec    = '0;
        case (state_reg)
            S_IDLE: begin
                if (pick_valid) begin
                    grant_vec[pick] = 1'b1;
                    chan_next       = pick;
                    ptr_next        = pick;
                    capt_next       = 1'b1;
                    int_next        = 1'b1;
                    state_next      = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                state_next = S_WAIT_RD;
            end
            S_WAIT_RD: begin
                if (RD_DONE) begin
                    rstcapt_next = 1'b1;
                    int_next     = 1'b0;
                    state_next   = S_REARM;
                end
            end
            S_REARM: begin
                cnt_next = '0;
                if (HOLDOFF > 0) begin
                    state_next = S_HOLDOFF;
                end else begin
                    state_next = S_IDLE;
                end
            end
            S_HOLDOFF: begin
                if (cnt_reg == HW'(HLAST)) begin
                    cnt_next   = '0;
                    state_next = S_IDLE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg   <= S_IDLE;
            capt_reg    <= 1'b0;
            rstcapt_reg <= 1'b0;
            int_reg     <= 1'b0;
            chan_reg    <= '0;
            ptr_reg     <= CW'(NCH - 1);
            cnt_reg     <= '0;
        end else begin
            state_reg   <= state_next;
            capt_reg    <= capt_next;
            rstcapt_reg <= rstcapt_next;
            int_reg     <= int_next;
            chan_reg    <= chan_next;
            ptr_reg     <= ptr_next;
            cnt_reg     <= cnt_next;
        end
    end

    assign CAPT_O    = capt_reg;
    assign RSTCAPT_O = rstcapt_reg;
    assign CHAN      = chan_reg;
    assign INT       = int_reg;
    assign PEND      = pend_reg;
    assign OVF       = ovf_reg;

endmodule

// File: tb/tb_capt_sched.sv
// Directed bench for capt_sched: NCH=4 with HOLDOFF=2, plus a HOLDOFF=0 instance
// for back-to-back throughput.
module tb_capt_sched;

    logic       CLK = 1'b0;
    logic       RST;
    logic [3:0] ev;
    logic       rd_done;
    logic       ovf_clr;
    logic       capt, rstcapt, intr;
    logic [1:0] chan;
    logic [3:0] pend, ovf;

    logic [3:0] ev2;
    logic       rd2;
    logic       ovf_clr2;
    logic       capt2, rstcapt2, int2;
    logic [1:0] chan2;
    logic [3:0] pend2, ovf2;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 CLK = ~CLK;

    capt_sched #(.NCH(4), .HOLDOFF(2)) dut (
        .CLK(CLK), .RST(RST), .EV(ev), .RD_DONE(rd_done), .OVF_CLR(ovf_clr),
        .CAPT_O(capt), .RSTCAPT_O(rstcapt), .CHAN(chan), .INT(intr),
        .PEND(pend), .OVF(ovf)
    );

    capt_sched #(.NCH(4), .HOLDOFF(0)) dut0 (
        .CLK(CLK), .RST(RST), .EV(ev2), .RD_DONE(rd2), .OVF_CLR(ovf_clr2),
        .CAPT_O(capt2), .RSTCAPT_O(rstcapt2), .CHAN(chan2), .INT(int2),
        .PEND(pend2), .OVF(ovf2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_capt(input int limit, output logic [1:0] ch);
        for (int i = 0; i < limit; i++) begin
            tick();
            if (capt) break;
        end
        chk("capt_seen", {31'd0, capt}, 1);
        ch = chan;
        $display("[TB] capture chan=%0d t=%0t", chan, $time);
    endtask

    // Called in WAIT_RD: read done, then wait through re-arm and holdoff back to IDLE.
    task automatic rd_done_rearm();
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
        tick();
        tick();
        tick();
    endtask

    task automatic finish_service();
        tick();
        rd_done_rearm();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] ch;
        int caps;
        int gap;
        RST = 1'b1; ev = '0; rd_done = 1'b0; ovf_clr = 1'b0;
        ev2 = '0; rd2 = 1'b0; ovf_clr2 = 1'b0;
        tick();
        chk("rst_capt", {31'd0, capt}, 0);
        chk("rst_rstcapt", {31'd0, rstcapt}, 0);
        chk("rst_chan", {30'd0, chan}, 0);
        chk("rst_int", {31'd0, intr}, 0);
        chk("rst_pend", {28'd0, pend}, 0);
        chk("rst_ovf", {28'd0, ovf}, 0);
        tick();
        RST = 1'b0;
        tick();
        chk("idle_int", {31'd0, intr}, 0);
        $display("[TB] reset done");

        // Simultaneous events: served 0,1,2,3 with no overflow.
        ev = 4'b1111;
        tick(); tick();
        ev = '0;
        for (int i = 0; i < 4; i++) begin
            wait_capt(12, ch);
            chk("simul_chan", {30'd0, ch}, i);
            finish_service();
        end
        chk("simul_ovf", {28'd0, ovf}, 0);

        // Single event on ch2 with exact latency, then holdoff before ch0.
        ev = 4'b0100;
        tick(); tick(); tick();
        chk("single_pend", {28'd0, pend}, 4'b0100);
        chk("single_early", {31'd0, capt}, 0);
        tick();
        chk("single_capt", {31'd0, capt}, 1);
        chk("single_chan", {30'd0, chan}, 2);
        chk("single_int", {31'd0, intr}, 1);
        chk("single_pend_clr", {28'd0, pend}, 0);
        $display("[TB] capture chan=%0d t=%0t", chan, $time);
        ev = '0;
        tick();
        chk("single_capt_fall", {31'd0, capt}, 0);
        chk("single_int_hold", {31'd0, intr}, 1);
        ev = 4'b0001;
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
        chk("rearm_rstcapt", {31'd0, rstcapt}, 1);
        chk("rearm_int", {31'd0, intr}, 0);
        chk("rearm_nocapt", {31'd0, capt}, 0);
        tick();
        chk("rearm_fall", {31'd0, rstcapt}, 0);
        chk("hold_nocapt1", {31'd0, capt}, 0);
        ev = '0;
        tick();
        chk("hold_nocapt2", {31'd0, capt}, 0);
        tick();
        chk("hold_nocapt3", {31'd0, capt}, 0);
        chk("hold_pend", {28'd0, pend}, 4'b0001);
        tick();
        chk("hold_capt", {31'd0, capt}, 1);
        chk("hold_chan", {30'd0, chan}, 0);
        $display("[TB] capture chan=%0d t=%0t", chan, $time);
        finish_service();

        // Round-robin: after ch1, ch0+ch2 together go 2 then 0.
        ev = 4'b0010;
        tick(); tick();
        ev = '0;
        wait_capt(12, ch);
        chk("rr_first", {30'd0, ch}, 1);
        finish_service();
        ev = 4'b0101;
        tick(); tick();
        ev = '0;
        wait_capt(12, ch);
        chk("rr_second", {30'd0, ch}, 2);
        finish_service();
        wait_capt(12, ch);
        chk("rr_third", {30'd0, ch}, 0);
        finish_service();

        // Overflow on ch1 while ch3 awaits readout.
        ev = 4'b1000;
        tick(); tick();
        ev = '0;
        wait_capt(12, ch);
        chk("ovf_svc_chan", {30'd0, ch}, 3);
        tick();
        ev = 4'b0010; tick(); tick(); ev = '0; tick(); tick();
        ev = 4'b0010; tick(); tick(); ev = '0; tick(); tick(); tick();
        chk("ovf_pend", {28'd0, pend}, 4'b0010);
        chk("ovf_flag", {28'd0, ovf}, 4'b0010);
        chk("ovf_int", {31'd0, intr}, 1);
        rd_done_rearm();
        wait_capt(12, ch);
        chk("ovf_capt_chan", {30'd0, ch}, 1);
        finish_service();
        caps = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            caps += int'(capt);
        end
        chk("ovf_one_capt", caps, 0);
        chk("ovf_sticky", {28'd0, ovf}, 4'b0010);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("ovf_cleared", {28'd0, ovf}, 0);

        // New ch1 overflow landing in the same cycle as OVF_CLR survives.
        ev = 4'b1000;
        tick(); tick();
        ev = '0;
        wait_capt(12, ch);
        tick();
        ev = 4'b0010; tick(); tick(); ev = '0; tick(); tick();
        ev = 4'b0010; tick(); tick(); ev = '0;
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("ovf_clr_coinc", {28'd0, ovf}, 4'b0010);
        rd_done_rearm();
        wait_capt(12, ch);
        chk("coinc_chan", {30'd0, ch}, 1);
        finish_service();
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;

        // RD_DONE in IDLE is ignored.
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
        chk("idle_rd_rstcapt", {31'd0, rstcapt}, 0);
        tick();
        chk("idle_rd_rstcapt2", {31'd0, rstcapt}, 0);

        // Asynchronous reset in the middle of WAIT_RD.
        ev = 4'b1000;
        tick(); tick();
        ev = '0;
        wait_capt(12, ch);
        tick();
        ev = 4'b0001; tick(); tick(); ev = '0; tick(); tick();
        ev = 4'b0101; tick(); tick(); ev = '0; tick();
        chk("pre_rst_pend", {28'd0, pend}, 4'b0101);
        chk("pre_rst_ovf", {28'd0, ovf}, 4'b0001);
        chk("pre_rst_int", {31'd0, intr}, 1);
        #2;
        RST = 1'b1;
        #1;
        chk("arst_int", {31'd0, intr}, 0);
        chk("arst_pend", {28'd0, pend}, 0);
        chk("arst_ovf", {28'd0, ovf}, 0);
        chk("arst_capt", {31'd0, capt}, 0);
        chk("arst_rstcapt", {31'd0, rstcapt}, 0);
        chk("arst_chan", {30'd0, chan}, 0);
        $display("[TB] async reset applied t=%0t", $time);
        tick();
        RST = 1'b0;
        ev = 4'b1000;
        tick(); tick();
        ev = '0;
        tick();
        chk("post_rst_early", {31'd0, capt}, 0);
        tick();
        chk("post_rst_capt", {31'd0, capt}, 1);
        chk("post_rst_chan", {30'd0, chan}, 3);
        $display("[TB] capture chan=%0d t=%0t", chan, $time);
        finish_service();

        // HOLDOFF=0 instance: captures exactly 4 cycles apart.
        ev2 = 4'b0011;
        tick(); tick();
        ev2 = '0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (capt2) break;
        end
        chk("h0_capt_seen", {31'd0, capt2}, 1);
        chk("h0_first_chan", {30'd0, chan2}, 0);
        tick();
        rd2 = 1'b1;
        tick();
        rd2 = 1'b0;
        chk("h0_rstcapt", {31'd0, rstcapt2}, 1);
        gap = 2;
        while (gap < 12) begin
            tick();
            gap++;
            if (capt2) break;
        end
        chk("h0_gap", gap, 4);
        chk("h0_second_chan", {30'd0, chan2}, 1);
        $display("[TB] holdoff0 capture gap=%0d chan=%0d", gap, chan2);
        tick();
        rd2 = 1'b1;
        tick();
        rd2 = 1'b0;
        tick(); tick();
        chk("h0_done_int", {31'd0, int2}, 0);
        chk("h0_done_pend", {28'd0, pend2}, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/capt_sched.md
# capt_sched

Capture scheduler for the timestamper counter. It shares the single capture latch between NCH asynchronous event inputs and grants them round-robin. For each grant it issues the CAPT pulse, reports the granted channel, holds INT until the host signals that the SPI readout is complete, then pulses RSTCAPT to re-arm the latch. It sits between the external event pins and the timestamper core, in the same CLK domain as the counter.

## Interface
- NCH, 4: number of event channels, legal range 2..16.
- HOLDOFF, 2: idle cycles after re-arm before the next grant. 0 means no holdoff.
- CW, max(1,clog2(NCH)): width of CHAN (derived, not overridden).

- CLK  in  1  system/count clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- EV  in  NCH  raw asynchronous event inputs. Rising edge is an event. Each input must stay high for at least 2 CLK periods.
- RD_DONE  in  1  single-cycle pulse, synchronous to CLK, meaning the captured value has been read.
- OVF_CLR  in  1  single-cycle pulse, synchronous to CLK, that clears all OVF bits.
- CAPT_O  out  1  one-cycle capture strobe to the timestamper.
- RSTCAPT_O  out  1  one-cycle re-arm strobe to the timestamper.
- CHAN  out  CW  channel of the current or most recent capture.
- INT  out  1  high while a captured value awaits readout.
- PEND  out  NCH  pending-event flags.
- OVF  out  NCH  sticky overflow flags, one per channel.

## Operation
- Per channel, a 3-flop chain s1→s2→s3 forms a 2-stage synchronizer plus edge register. An edge is detected when s2 & ~s3.
- Pending:
  - A detected edge sets PEND[i].
  - If PEND[i] is already 1, OVF[i] is set and PEND stays 1, so only one capture is issued.
  - A grant clears PEND[i]. If an edge is detected on that channel in the same cycle, PEND[i] stays 1 and no overflow is flagged.
- OVF: OVF_CLR clears all bits. If a new overflow occurs in the same cycle as OVF_CLR, that bit stays set.
- Arbiter:
  - Round-robin; ptr holds the last granted channel.
  - Search starts at ptr+1 and wraps modulo NCH.
  - Reset value of ptr is NCH-1, so channel 0 is served first.
- States:
  - IDLE: if PEND≠0, grant the channel, load CHAN, update ptr, then go to CAPTURE. Otherwise stay in IDLE.
  - CAPTURE: CAPT_O=1 and INT=1, for one cycle. Then go to WAIT_RD.
  - WAIT_RD: INT=1. On RD_DONE go to REARM. RD_DONE in any other state is ignored.
  - REARM: RSTCAPT_O=1, INT=0, for one cycle. Then go to HOLDOFF, or to IDLE if HOLDOFF=0.
  - HOLDOFF: count HOLDOFF cycles, then go to IDLE.
- Events keep accumulating in PEND during every state. An event on the channel currently being serviced becomes a new pending, not an overflow.
- CHAN holds its value until the next grant.
- All outputs are registered.

## Timing
- Reset values: CAPT_O=0, RSTCAPT_O=0, INT=0, CHAN=0, PEND=0, OVF=0. State=IDLE, ptr=NCH-1, sync flops=0, holdoff counter=0.
- Reset is asynchronous: it takes effect immediately, in any state, including mid-WAIT_RD. It does not reset the timestamper itself.
- Event latency: EV rises with setup before edge k →
  - s1 at k, s2 at k+1;
  - PEND[i]=1 after k+2;
  - CAPT_O, INT and CHAN valid after k+3, assuming IDLE;
  - CAPT_O falls after k+4.
- RD_DONE sampled at edge r in WAIT_RD → RSTCAPT_O high and INT low after r+1. RSTCAPT_O falls after r+2.
- Earliest next CAPT_O: after r+3+HOLDOFF.
- Back-to-back service with RD_DONE given immediately: one capture per 4+HOLDOFF cycles.

## Test plan
- Single event: NCH=4, HOLDOFF=2, EV[2] rises before edge k → CAPT_O pulses one cycle after k+3, CHAN=2, INT=1, PEND=0000. RD_DONE at edge r → RSTCAPT_O high after r+1, INT=0. No CAPT_O before r+5.
- Simultaneous events: EV[3:0]=1111 at one edge → grants in order CHAN=0,1,2,3, each CAPT_O following the previous RD_DONE. OVF stays 0000.
- Round-robin: after serving ch1, assert EV[0] and EV[2] together → ch2 granted first, then ch0.
- Overflow: EV[1] pulses twice, 4 cycles apart, while the FSM sits in WAIT_RD for ch3 → PEND[1]=1, OVF=0010, and exactly one later capture with CHAN=1. OVF_CLR → OVF=0000. OVF_CLR coincident with a new ch1 overflow → OVF=0010.
- Ignore and reset: RD_DONE pulse in IDLE → no RSTCAPT_O. RST asserted mid-WAIT_RD with PEND=0101 → INT, PEND, OVF, CAPT_O and RSTCAPT_O all 0 immediately. After release, the first event on ch3 is granted with CHAN=3 in 4 cycles.
- HOLDOFF=0 build: PEND=0011, RD_DONE asserted on the first WAIT_RD cycle each time → CAPT_O pulses exactly 4 cycles apart.
